// File: rtl/self_test_pkg.sv
`default_nettype none
// ============================================================================
// Module   : self_test_pkg
// Purpose  : Shared definitions for the self-test result monitor. Holds the
//            monitor FSM state encoding, the report framing constants and a
//            helper that assembles the report header word.
// Contents : state_e        - IDLE / ARMED / REPORT / DONE
//            RPT_MAGIC      - tag in the top byte of report word 0
//            RPT_WORDS      - number of words in one report
//            HDR_*          - bit positions of the header fields
//            build_header() - packs magic, pass, timeout and status
// Revision : 1.0 - initial release
// ============================================================================
package self_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_REPORT = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [7:0] RPT_MAGIC       = 8'hA5;
    localparam int         RPT_WORDS       = 4;
    localparam int         RPT_IDX_W       = 2;
    localparam int         STATUS_W        = 3;

    localparam int         HDR_MAGIC_LSB   = 24;
    localparam int         HDR_PASS_BIT    = 4;
    localparam int         HDR_TIMEOUT_BIT = 3;
    localparam int         HDR_STATUS_LSB  = 0;

    // Header word: {magic, 19'b0, pass, timeout, status}
    function automatic logic [31:0] build_header(
        input logic                pass,
        input logic                timeout,
        input logic [STATUS_W-1:0] status
    );
        logic [31:0] hdr;
        hdr                                   = '0;
        hdr[HDR_MAGIC_LSB +: 8]               = RPT_MAGIC;
        hdr[HDR_PASS_BIT]                     = pass;
        hdr[HDR_TIMEOUT_BIT]                  = timeout;
        hdr[HDR_STATUS_LSB +: STATUS_W]       = status;
        return hdr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/self_test_report_tx.sv
`default_nettype none
// ============================================================================
// Module   : self_test_report_tx
// Purpose  : Streams the four captured report words over a valid/ready port.
//            A load pulse restarts the word index at 0 and raises valid; the
//            index advances only on an accepted transfer, and valid drops
//            after the last word is accepted.
// Ports    : clk            in   clock, rising edge
//            reset          in   synchronous active-low reset
//            i_load         in   start a new report (one-cycle pulse)
//            i_word0..3     in   report words, held stable by the caller
//            i_rpt_ready    in   host accepts the current word
//            o_rpt_data     out  current report word (0 while idle)
//            o_rpt_valid    out  report word valid
//            o_last_accept  out  pulse: final word accepted this cycle
// Revision : 1.0 - initial release
// ============================================================================
module self_test_report_tx
    import self_test_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic [31:0] i_word0,
    input  logic [31:0] i_word1,
    input  logic [31:0] i_word2,
    input  logic [31:0] i_word3,
    input  logic        i_rpt_ready,
    output logic [31:0] o_rpt_data,
    output logic        o_rpt_valid,
    output logic        o_last_accept
);

    localparam logic [RPT_IDX_W-1:0] C_LAST_IDX = RPT_IDX_W'(RPT_WORDS - 1);

    logic [RPT_IDX_W-1:0] idx_q;
    logic [RPT_IDX_W-1:0] idx_d;
    logic                 valid_q;
    logic                 valid_d;
    logic                 w_xfer;
    logic [31:0]          w_word;

    assign w_xfer        = valid_q & i_rpt_ready;
    assign o_last_accept = w_xfer & (idx_q == C_LAST_IDX);

    always_comb begin
        idx_d   = idx_q;
        valid_d = valid_q;
        if (i_load) begin
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (w_xfer) begin
            // Index wraps back to 0 after the last word; valid closes the report.
            idx_d = idx_q + 1'b1;
            if (idx_q == C_LAST_IDX) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        w_word = '0;
        case (idx_q)
            2'd0:    w_word = i_word0;
            2'd1:    w_word = i_word1;
            2'd2:    w_word = i_word2;
            default: w_word = i_word3;
        endcase
    end

    // Data is forced to zero outside a report so the port is quiet when idle.
    assign o_rpt_data  = valid_q ? w_word : 32'd0;
    assign o_rpt_valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/self_test_monitor.sv
`default_nettype none
// ============================================================================
// Module   : self_test_monitor
// Purpose  : Consumer end of the self-tester result interface. Arms on
//            i_start, watches the tester done level for a rising edge while a
//            watchdog counts, then snapshots status/count/perf and the
//            watchdog value and streams a 4-word report to the host.
// Params   : TIMEOUT_CYCLES  watchdog limit after arm (0 disables it)
//            PASS_STATUS     status code meaning "passed"
//            EXP_COUNT       required result count (0 = not checked)
// Ports    : clk             in   clock, rising edge
//            reset           in   synchronous active-low reset
//            i_start         in   arm pulse, honoured in IDLE or DONE
//            i_test_status   in   tester status code (3 bits)
//            i_result_count  in   tester result count
//            i_perf_counter  in   tester perf counter
//            i_test_done     in   tester done level
//            o_rpt_data      out  report word
//            o_rpt_valid     out  report word valid
//            i_rpt_ready     in   host ready
//            o_busy          out  armed or reporting
//            o_pass          out  verdict, valid in DONE
//            o_timeout       out  watchdog fired this run
// Revision : 1.0 - initial release
// ============================================================================
module self_test_monitor
    import self_test_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [2:0]  PASS_STATUS    = 3'd1,
    parameter logic [31:0] EXP_COUNT      = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [2:0]  i_test_status,
    input  logic [31:0] i_result_count,
    input  logic [31:0] i_perf_counter,
    input  logic        i_test_done,
    output logic [31:0] o_rpt_data,
    output logic        o_rpt_valid,
    input  logic        i_rpt_ready,
    output logic        o_busy,
    output logic        o_pass,
    output logic        o_timeout
);

    localparam logic        C_WDOG_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] C_WDOG_LIMIT = 32'(TIMEOUT_CYCLES - 32'd1);

    state_e      state_q,       state_d;
    logic        done_q,        done_d;
    logic [31:0] wdog_q,        wdog_d;
    logic [2:0]  snap_status_q, snap_status_d;
    logic [31:0] snap_count_q,  snap_count_d;
    logic [31:0] snap_perf_q,   snap_perf_d;
    logic [31:0] snap_wdog_q,   snap_wdog_d;
    logic        snap_pass_q,   snap_pass_d;
    logic        timeout_q,     timeout_d;
    logic        pass_q,        pass_d;

    logic        w_done_edge;
    logic        w_timeout_hit;
    logic        w_capture;
    logic        w_count_ok;
    logic        w_cap_pass;
    logic        w_load;
    logic        w_last_accept;
    logic [31:0] w_word0;

    // done_q tracks the done level every cycle, so a level that is already
    // high when the monitor arms never looks like an edge.
    assign w_done_edge   = i_test_done & ~done_q;
    // A done edge in the same cycle as the limit takes priority over timeout.
    assign w_timeout_hit = C_WDOG_EN & (wdog_q == C_WDOG_LIMIT) & ~w_done_edge;
    assign w_capture     = w_done_edge | w_timeout_hit;
    assign w_count_ok    = (EXP_COUNT == 32'd0) | (i_result_count == EXP_COUNT);
    assign w_cap_pass    = (i_test_status == PASS_STATUS) & ~w_timeout_hit & w_count_ok;

    always_comb begin
        state_d       = state_q;
        done_d        = i_test_done;
        wdog_d        = wdog_q;
        snap_status_d = snap_status_q;
        snap_count_d  = snap_count_q;
        snap_perf_d   = snap_perf_q;
        snap_wdog_d   = snap_wdog_q;
        snap_pass_d   = snap_pass_q;
        timeout_d     = timeout_q;
        pass_d        = pass_q;
        w_load        = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_d   = ST_ARMED;
                    wdog_d    = 32'd0;
                    timeout_d = 1'b0;
                    pass_d    = 1'b0;
                end
            end
            ST_ARMED: begin
                if (wdog_q != 32'hFFFF_FFFF) begin
                    wdog_d = wdog_q + 32'd1;
                end
                if (w_capture) begin
                    snap_status_d = i_test_status;
                    snap_count_d  = i_result_count;
                    snap_perf_d   = i_perf_counter;
                    snap_wdog_d   = wdog_q;
                    snap_pass_d   = w_cap_pass;
                    timeout_d     = w_timeout_hit;
                    w_load        = 1'b1;
                    state_d       = ST_REPORT;
                end
            end
            ST_REPORT: begin
                // The verdict is published only once the host has the whole report.
                if (w_last_accept) begin
                    state_d = ST_DONE;
                    pass_d  = snap_pass_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            done_q        <= 1'b0;
            wdog_q        <= 32'd0;
            snap_status_q <= 3'd0;
            snap_count_q  <= 32'd0;
            snap_perf_q   <= 32'd0;
            snap_wdog_q   <= 32'd0;
            snap_pass_q   <= 1'b0;
            timeout_q     <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            done_q        <= done_d;
            wdog_q        <= wdog_d;
            snap_status_q <= snap_status_d;
            snap_count_q  <= snap_count_d;
            snap_perf_q   <= snap_perf_d;
            snap_wdog_q   <= snap_wdog_d;
            snap_pass_q   <= snap_pass_d;
            timeout_q     <= timeout_d;
            pass_q        <= pass_d;
        end
    end

    assign w_word0 = build_header(snap_pass_q, timeout_q, snap_status_q);

    self_test_report_tx u_report_tx (
        .clk           (clk),
        .reset         (reset),
        .i_load        (w_load),
        .i_word0       (w_word0),
        .i_word1       (snap_count_q),
        .i_word2       (snap_perf_q),
        .i_word3       (snap_wdog_q),
        .i_rpt_ready   (i_rpt_ready),
        .o_rpt_data    (o_rpt_data),
        .o_rpt_valid   (o_rpt_valid),
        .o_last_accept (w_last_accept)
    );

    assign o_busy    = (state_q == ST_ARMED) | (state_q == ST_REPORT);
    assign o_pass    = pass_q;
    assign o_timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_self_test_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_self_test_monitor
// Purpose  : Bench for self_test_monitor. Two instances share stimulus: one
//            with the result count unchecked, one requiring a count of 256.
//            Expected reports are pushed into per-instance queues when a run
//            is issued; a negedge monitor pops and compares transferred words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_self_test_monitor;

    localparam int          TMO    = 100;
    localparam logic [31:0] EXPC_B = 32'd256;
    localparam int          RPT_N  = 4;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  status;
    logic [31:0] count;
    logic [31:0] perf;
    logic        done;
    logic        ready;

    logic [31:0] data_a, data_b;
    logic        valid_a, valid_b;
    logic        busy_a, busy_b;
    logic        pass_a, pass_b;
    logic        tmo_a, tmo_b;

    int passed;
    int total;

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic        prev_stall[2];

    self_test_monitor #(
        .TIMEOUT_CYCLES (TMO),
        .PASS_STATUS    (3'd1),
        .EXP_COUNT      (32'd0)
    ) dut_a (
        .clk            (clk),
        .reset          (reset),
        .i_start        (start),
        .i_test_status  (status),
        .i_result_count (count),
        .i_perf_counter (perf),
        .i_test_done    (done),
        .o_rpt_data     (data_a),
        .o_rpt_valid    (valid_a),
        .i_rpt_ready    (ready),
        .o_busy         (busy_a),
        .o_pass         (pass_a),
        .o_timeout      (tmo_a)
    );

    self_test_monitor #(
        .TIMEOUT_CYCLES (TMO),
        .PASS_STATUS    (3'd1),
        .EXP_COUNT      (EXPC_B)
    ) dut_b (
        .clk            (clk),
        .reset          (reset),
        .i_start        (start),
        .i_test_status  (status),
        .i_result_count (count),
        .i_perf_counter (perf),
        .i_test_done    (done),
        .o_rpt_data     (data_b),
        .o_rpt_valid    (valid_b),
        .i_rpt_ready    (ready),
        .o_busy         (busy_b),
        .o_pass         (pass_b),
        .o_timeout      (tmo_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Reference model: report header and verdict straight from the rules.
    function automatic logic [31:0] model_hdr(input logic p, input logic t, input logic [2:0] s);
        return 32'hA500_0000 | {27'd0, p, t, s};
    endfunction

    function automatic logic model_pass(input logic [2:0] s, input logic [31:0] c,
                                        input logic t, input logic [31:0] expc);
        return (s == 3'd1) && !t && ((expc == 32'd0) || (c == expc));
    endfunction

    task automatic mon_one(input int d, input logic [31:0] dat, input logic vld, input logic bsy);
        int n;
        logic [31:0] exp_w;
        n = (d == 0) ? exp_q0.size() : exp_q1.size();
        if (vld) begin
            check_bit($sformatf("busy_in_report_dut%0d", d), bsy, 1'b1);
            if (n == 0) begin
                total++;
                $display("FAIL extra_word_dut%0d: got %h, required no word", d, dat);
            end else begin
                exp_w = (d == 0) ? exp_q0[0] : exp_q1[0];
                check($sformatf("rpt_word%0d_dut%0d", RPT_N - n, d), dat, exp_w);
                if (ready) begin
                    if (d == 0) void'(exp_q0.pop_front());
                    else        void'(exp_q1.pop_front());
                end
            end
        end else if (prev_stall[d]) begin
            check_bit($sformatf("valid_held_in_stall_dut%0d", d), vld, 1'b1);
        end
        prev_stall[d] = vld & ~ready;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            prev_stall[0] = 1'b0;
            prev_stall[1] = 1'b0;
        end else begin
            mon_one(0, data_a, valid_a, busy_a);
            mon_one(1, data_b, valid_b, busy_b);
        end
    end

    task automatic rand_tester();
        status = 3'($urandom_range(0, 7));
        count  = $urandom;
        perf   = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s_data_a", tag), data_a, 32'd0);
        check($sformatf("%s_data_b", tag), data_b, 32'd0);
        check_bit($sformatf("%s_valid_a", tag), valid_a, 1'b0);
        check_bit($sformatf("%s_valid_b", tag), valid_b, 1'b0);
        check_bit($sformatf("%s_busy_a", tag), busy_a, 1'b0);
        check_bit($sformatf("%s_busy_b", tag), busy_b, 1'b0);
        check_bit($sformatf("%s_pass_a", tag), pass_a, 1'b0);
        check_bit($sformatf("%s_pass_b", tag), pass_b, 1'b0);
        check_bit($sformatf("%s_timeout_a", tag), tmo_a, 1'b0);
        check_bit($sformatf("%s_timeout_b", tag), tmo_b, 1'b0);
    endtask

    // One run: arm, done rising edge k cycles after the arm edge (or timeout
    // when k exceeds the limit), then drain the report with the chosen ready
    // pattern (0 = always, 1 = five stall cycles per word, 2 = random).
    // abort_at >= 0 applies reset once that many words have been accepted.
    // Called and returns at posedge+1.
    task automatic run_test(input int k_in, input bit d0, input logic [2:0] st,
                            input logic [31:0] cnt, input logic [31:0] pf,
                            input int mode, input int abort_at);
        int   k, cap_i, cyc, stall;
        logic t, pa, pb;
        bit   first;
        k = k_in;
        if (d0 && k < 3) k = 3;
        t     = (k > TMO);
        cap_i = t ? TMO : k;

        start = 1'b1;
        done  = d0;
        rand_tester();
        @(posedge clk); #1;
        start = 1'b0;

        for (int i = 1; i <= cap_i; i++) begin
            if (i == cap_i) begin
                status = st; count = cnt; perf = pf;
            end else begin
                rand_tester();
            end
            done  = (i == k) ? 1'b1 : (d0 && i == 1);
            start = ($urandom_range(0, 1) == 1);
            ready = ($urandom_range(0, 1) == 1);
            if (i == 1) begin
                @(negedge clk);
                check_bit("armed_busy_a", busy_a, 1'b1);
                check_bit("armed_valid_a", valid_a, 1'b0);
                check_bit("armed_pass_cleared_a", pass_a, 1'b0);
                check_bit("armed_timeout_cleared_b", tmo_b, 1'b0);
            end
            @(posedge clk); #1;
        end

        pa = model_pass(st, cnt, t, 32'd0);
        pb = model_pass(st, cnt, t, EXPC_B);
        exp_q0.push_back(model_hdr(pa, t, st));
        exp_q0.push_back(cnt);
        exp_q0.push_back(pf);
        exp_q0.push_back(32'(cap_i - 1));
        exp_q1.push_back(model_hdr(pb, t, st));
        exp_q1.push_back(cnt);
        exp_q1.push_back(pf);
        exp_q1.push_back(32'(cap_i - 1));

        stall = 0; first = 1'b1; cyc = 0;
        while (1) begin
            if (abort_at >= 0 && exp_q0.size() == RPT_N - abort_at) break;
            if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
            if (cyc >= 300) break;
            case (mode)
                0:       ready = 1'b1;
                1:       ready = (stall == 5);
                default: ready = ($urandom_range(0, 1) == 1);
            endcase
            stall = (stall == 5) ? 0 : stall + 1;
            start = ($urandom_range(0, 1) == 1);
            done  = ($urandom_range(0, 1) == 1);
            rand_tester();
            if (first) begin
                first = 1'b0;
                @(negedge clk);
                check_bit("report_latency_valid_a", valid_a, 1'b1);
                check_bit("report_latency_valid_b", valid_b, 1'b1);
                check_bit("timeout_flag_a", tmo_a, t);
                check_bit("timeout_flag_b", tmo_b, t);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;

        if (cyc >= 300) begin
            total++;
            $display("FAIL report_drain: %0d words still pending after %0d cycles, required 0",
                     exp_q0.size() + exp_q1.size(), cyc);
            exp_q0.delete();
            exp_q1.delete();
        end

        if (abort_at >= 0) begin
            reset = 1'b0;
            ready = 1'b0;
            @(posedge clk); #1;
            exp_q0.delete();
            exp_q1.delete();
            @(negedge clk);
            check_all_zero("abort_reset");
            @(posedge clk); #1;
            reset = 1'b1;
        end else begin
            @(negedge clk);
            check_bit("done_valid_a", valid_a, 1'b0);
            check_bit("done_valid_b", valid_b, 1'b0);
            check_bit("done_busy_a", busy_a, 1'b0);
            check_bit("done_busy_b", busy_b, 1'b0);
            check_bit("verdict_a", pass_a, pa);
            check_bit("verdict_b", pass_b, pb);
            check_bit("done_timeout_a", tmo_a, t);
            check_bit("done_timeout_b", tmo_b, t);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: simulation still running, required completion");
        $fatal(1, "time limit");
    end

    initial begin
        passed = 0;
        total  = 0;
        prev_stall[0] = 1'b0;
        prev_stall[1] = 1'b0;
        reset = 1'b0;
        start = 1'b0;
        status = 3'd0;
        count = 32'd0;
        perf = 32'd0;
        done = 1'b0;
        ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_state");
        @(posedge clk); #1;
        reset = 1'b1;

        // Nominal pass: words A5000011, 100, 3E8, 31
        run_test(50, 1'b0, 3'd1, 32'd256, 32'd1000, 0, -1);
        // Watchdog expiry: timeout flag set, w3 = 0x63, no pass
        run_test(200, 1'b0, 3'd1, 32'd256, 32'd1000, 2, -1);
        // Stalls of five cycles on every word
        run_test(30, 1'b0, 3'd1, 32'd7, 32'd55, 1, -1);
        // Done already high at arm; only the later rising edge counts
        run_test(20, 1'b1, 3'd1, 32'd256, 32'd77, 0, -1);
        // Count mismatch for the checked instance, then bad status
        run_test(40, 1'b0, 3'd1, 32'd255, 32'd9, 0, -1);
        run_test(40, 1'b0, 3'd2, 32'd255, 32'd9, 0, -1);
        // Done edge on the very cycle the watchdog limit is reached: done wins
        run_test(TMO, 1'b0, 3'd1, 32'd256, 32'hDEAD_BEEF, 2, -1);
        // Done edge in the first armed cycle
        run_test(1, 1'b0, 3'd1, 32'd256, 32'd3, 0, -1);
        // Reset in the middle of word 2, then a fresh full report
        run_test(25, 1'b0, 3'd1, 32'd256, 32'd5, 0, 2);
        run_test(35, 1'b0, 3'd1, 32'd256, 32'd6, 2, -1);

        repeat (20) begin
            run_test($urandom_range(1, 130), ($urandom_range(0, 1) == 1),
                     ($urandom_range(0, 1) == 1) ? 3'd1 : 3'($urandom_range(0, 7)),
                     ($urandom_range(0, 1) == 1) ? 32'd256 : $urandom,
                     $urandom, $urandom_range(0, 2), -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
